// File: rtl/rambyte_stream_loader.sv
// rambyte_stream_loader: sequences a byte-wide synchronous block RAM.
// LOAD writes an incoming valid/ready byte stream into RAM starting at a
// latched address; DUMP reads a region back out as a valid/ready stream.
// While busy this block is the only driver of the RAM port.
module rambyte_stream_loader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_LOAD,
  input  logic              CMD_DUMP,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [LEN_W-1:0]  LENGTH,
  output logic              BUSY,
  output logic              DONE,
  input  logic [7:0]        S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic [7:0]        M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [7:0]        RAM_DI,
  input  logic [7:0]        RAM_DO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD,
    ST_CAP,
    ST_OUT,
    ST_FIN
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [LEN_W-1:0]   remaining;
  logic [7:0]         m_data;

  // Command sequencing: address/length bookkeeping and state transitions.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      m_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CMD_LOAD || CMD_DUMP) begin
            addr      <= START_ADDR;
            remaining <= LENGTH;
            if (LENGTH == '0)
              state <= ST_FIN;
            else if (CMD_LOAD)
              state <= ST_LOAD;
            else
              state <= ST_RD;
          end
        end
        ST_LOAD: begin
          if (S_VALID) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1))
              state <= ST_FIN;
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          m_data <= RAM_DO;
          state  <= ST_OUT;
        end
        ST_OUT: begin
          if (M_READY) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state <= ST_FIN;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_RD;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status, stream and RAM port outputs decoded from the state register.
  // RAM_DI follows S_DATA only in LOAD so it reads 0 under reset and idle.
  always_comb begin
    BUSY     = (state != ST_IDLE);
    DONE     = (state == ST_FIN);
    S_READY  = (state == ST_LOAD);
    M_VALID  = (state == ST_OUT);
    M_DATA   = m_data;
    RAM_WE   = (state == ST_LOAD) && S_VALID;
    RAM_EN   = ((state == ST_LOAD) && S_VALID) || (state == ST_RD);
    RAM_ADDR = addr;
    RAM_DI   = (state == ST_LOAD) ? S_DATA : '0;
  end

endmodule

// File: tb/tb_rambyte_stream_loader.sv
// Bench for rambyte_stream_loader: behavioural RAM, queue-based model of
// expected writes / reads / output bytes, per-cycle compare process and
// directed scenarios with literal expectations.
module tb_rambyte_stream_loader;

  localparam int ADDR_W = 14;
  localparam int LEN_W  = 15;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              CMD_LOAD = 1'b0;
  logic              CMD_DUMP = 1'b0;
  logic [ADDR_W-1:0] START_ADDR = '0;
  logic [LEN_W-1:0]  LENGTH = '0;
  logic              BUSY, DONE;
  logic [7:0]        S_DATA = '0;
  logic              S_VALID = 1'b0;
  logic              S_READY;
  logic [7:0]        M_DATA;
  logic              M_VALID;
  logic              M_READY = 1'b0;
  logic              RAM_EN, RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [7:0]        RAM_DI;
  logic [7:0]        RAM_DO = '0;

  rambyte_stream_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .CMD_LOAD(CMD_LOAD), .CMD_DUMP(CMD_DUMP),
    .START_ADDR(START_ADDR), .LENGTH(LENGTH), .BUSY(BUSY), .DONE(DONE),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
    .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM and reference image
  logic [7:0] ram     [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];

  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) ram[RAM_ADDR] <= RAM_DI;
      else        RAM_DO <= ram[RAM_ADDR];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int exp_wr_a[$], exp_wr_d[$], exp_rd[$], exp_out[$];
  int wr_log[$], got_log[$], hs_cyc[$];

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int dat(input int seed, input int step, input int i);
    return (seed + i * step) & 255;
  endfunction

  function automatic int init_pat(input int a);
    return (a & 255) ^ 8'h5A;
  endfunction

  // Compare process: every RAM access and output byte against the model queues
  always @(negedge CLK) begin
    if (!RST) begin
      cyc++;
      chk("we_implies_en", int'(RAM_WE & ~RAM_EN), 0);
      if (RAM_EN && RAM_WE) begin
        if (exp_wr_a.size() == 0) chk("spurious_write", 1, 0);
        else begin
          chk("wr_addr", int'(RAM_ADDR), exp_wr_a.pop_front());
          chk("wr_data", int'(RAM_DI), exp_wr_d.pop_front());
          wr_log.push_back(int'(RAM_ADDR));
        end
      end
      if (RAM_EN && !RAM_WE) begin
        rd_cnt++;
        if (exp_rd.size() == 0) chk("spurious_read", 1, 0);
        else chk("rd_addr", int'(RAM_ADDR), exp_rd.pop_front());
      end
      if (M_VALID) begin
        if (exp_out.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("m_data", int'(M_DATA), exp_out[0]);
          if (M_READY) begin
            void'(exp_out.pop_front());
            got_log.push_back(int'(M_DATA));
            hs_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic issue(input bit ld, input bit dp, input int st, input int len);
    @(posedge CLK); #1;
    CMD_LOAD = ld; CMD_DUMP = dp;
    START_ADDR = ADDR_W'(st); LENGTH = LEN_W'(len);
    @(posedge CLK); #1;
    CMD_LOAD = 1'b0; CMD_DUMP = 1'b0;
    chk("busy_after_cmd", int'(BUSY), 1);
  endtask

  task automatic wait_done(input string name, output int waited);
    int n = 0;
    while (n < 1000 && !DONE) begin
      @(negedge CLK);
      if (!DONE) n++;
    end
    waited = n;
    chk(name, int'(DONE), 1);
    @(posedge CLK); #1;
    chk("idle_after_done", int'(BUSY), 0);
  endtask

  task automatic run_load(input bit ld, input bit dp, input int st, input int len,
                          input int seed, input int step, input bit gaps,
                          output int cycles, output int waited);
    int idx = 0;
    int n = 0;
    bit hs;
    wr_log.delete();
    for (int i = 0; i < len; i++) begin
      int a = (st + i) % DEPTH;
      exp_wr_a.push_back(a);
      exp_wr_d.push_back(dat(seed, step, i));
      ref_mem[a] = 8'(dat(seed, step, i));
    end
    issue(ld, dp, st, len);
    while (idx < len && n < len + 200) begin
      S_VALID = gaps ? ((n % 2) == 0) : 1'b1;
      S_DATA  = 8'(dat(seed, step, idx));
      @(negedge CLK);
      hs = S_READY && S_VALID;
      @(posedge CLK); #1;
      if (hs) idx++;
      n++;
    end
    S_VALID = 1'b0;
    cycles = n;
    chk("load_all_accepted", idx, len);
    wait_done("load_done", waited);
    chk("load_writes_drained", exp_wr_a.size(), 0);
  endtask

  task automatic run_dump(input int st, input int len, input int stall);
    int wc = 0;
    int n = 0;
    bit done = 0;
    got_log.delete(); hs_cyc.delete();
    for (int i = 0; i < len; i++) begin
      int a = (st + i) % DEPTH;
      exp_rd.push_back(a);
      exp_out.push_back(int'(ref_mem[a]));
    end
    M_READY = (stall == 0);
    rd_cnt = 0;
    issue(1'b0, 1'b1, st, len);
    while (!done && n < len * (stall + 6) + 50) begin
      @(negedge CLK);
      if (DONE) done = 1;
      else begin
        @(posedge CLK); #1;
        if (M_VALID) begin
          if (wc >= stall) M_READY = 1'b1;
          else begin M_READY = 1'b0; wc++; end
        end else begin
          M_READY = (stall == 0);
          wc = 0;
        end
        n++;
      end
    end
    chk("dump_done", int'(done), 1);
    @(posedge CLK); #1;
    chk("idle_after_dump", int'(BUSY), 0);
    chk("dump_rd_pulses", rd_cnt, len);
    chk("dump_bytes_count", got_log.size(), len);
    chk("dump_out_drained", exp_out.size(), 0);
    M_READY = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    int'(BUSY), 0);
    chk({tag, "_done"},    int'(DONE), 0);
    chk({tag, "_s_ready"}, int'(S_READY), 0);
    chk({tag, "_m_valid"}, int'(M_VALID), 0);
    chk({tag, "_m_data"},  int'(M_DATA), 0);
    chk({tag, "_ram_en"},  int'(RAM_EN), 0);
    chk({tag, "_ram_we"},  int'(RAM_WE), 0);
    chk({tag, "_ram_addr"}, int'(RAM_ADDR), 0);
    chk({tag, "_ram_di"},  int'(RAM_DI), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, waited;
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]     = 8'(init_pat(a));
      ref_mem[a] = 8'(init_pat(a));
    end

    // Reset state, with stream inputs active
    S_VALID = 1'b1; S_DATA = 8'hFF;
    #3;
    chk_all_zero("reset");
    S_VALID = 1'b0; S_DATA = '0;
    #20; @(posedge CLK); #1; RST = 1'b0;

    // 1: LOAD 0x0010, 4 bytes A0..A3, S_VALID always 1
    run_load(1'b1, 1'b0, 'h0010, 4, 'hA0, 1, 1'b0, cycles, waited);
    chk("t1_consecutive_writes", cycles, 4);
    chk("t1_done_latency", waited, 0);
    chk("t1_wr_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_wr_addr_lit", wr_log[i], 'h10 + i);

    // 2: DUMP same region, M_READY high: 3-cycle spacing
    run_dump('h0010, 4, 0);
    for (int i = 0; i < 4; i++) chk("t2_byte_lit", got_log[i], 'hA0 + i);
    for (int i = 0; i < 3; i++) chk("t2_spacing", hs_cyc[i+1] - hs_cyc[i], 3);

    // 3: DUMP with 5 stall cycles per byte
    run_dump('h0010, 4, 5);
    for (int i = 0; i < 4; i++) chk("t3_byte_lit", got_log[i], 'hA0 + i);
    for (int i = 0; i < 3; i++) chk("t3_spacing", hs_cyc[i+1] - hs_cyc[i], 8);

    // 4: LOAD across the top of the address space, with S_VALID gaps
    run_load(1'b1, 1'b0, 'h3FFE, 3, 'hC5, 'h11, 1'b1, cycles, waited);
    chk("t4_wr_addr0", wr_log[0], 'h3FFE);
    chk("t4_wr_addr1", wr_log[1], 'h3FFF);
    chk("t4_wr_addr2", wr_log[2], 'h0000);
    run_dump('h3FFE, 3, 0);
    chk("t4_rb0", got_log[0], 'hC5);
    chk("t4_rb1", got_log[1], 'hD6);
    chk("t4_rb2", got_log[2], 'hE7);

    // 5a: LENGTH=0 DUMP
    rd_cnt = 0; wr_log.delete();
    issue(1'b0, 1'b1, 'h0100, 0);
    @(negedge CLK);
    chk("t5_len0_done", int'(DONE), 1);
    @(posedge CLK); #1;
    chk("t5_len0_idle", int'(BUSY), 0);
    chk("t5_len0_no_reads", rd_cnt, 0);
    chk("t5_len0_no_writes", wr_log.size(), 0);
    // 5b: both commands -> LOAD wins
    run_load(1'b1, 1'b1, 'h0200, 3, 'h31, 'h05, 1'b0, cycles, waited);
    chk("t5_both_writes", wr_log.size(), 3);
    run_dump('h0200, 3, 0);
    chk("t5_both_rb0", got_log[0], 'h31);
    chk("t5_both_rb2", got_log[2], 'h3B);

    // 6: reset after 2 of 4 LOAD bytes
    wr_log.delete();
    for (int i = 0; i < 2; i++) begin
      exp_wr_a.push_back('h300 + i);
      exp_wr_d.push_back(dat('h11, 'h22, i));
      ref_mem['h300 + i] = 8'(dat('h11, 'h22, i));
    end
    issue(1'b1, 1'b0, 'h0300, 4);
    S_VALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      S_DATA = 8'(dat('h11, 'h22, i));
      @(posedge CLK); #1;
    end
    S_DATA = 8'(dat('h11, 'h22, 2));
    RST = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    @(posedge CLK); #1;
    S_VALID = 1'b0; RST = 1'b0;
    chk("t6_writes_before_rst", wr_log.size(), 2);
    chk("t6_no_pending_writes", exp_wr_a.size(), 0);
    run_dump('h0300, 4, 0);
    chk("t6_rb0", got_log[0], 'h11);
    chk("t6_rb1", got_log[1], 'h33);
    chk("t6_rb2", got_log[2], 'h58);
    chk("t6_rb3", got_log[3], 'h59);

    // Whole-RAM LOAD: final address wraps to just below START_ADDR
    run_load(1'b1, 1'b0, 'h1234, DEPTH, 'h07, 3, 1'b0, cycles, waited);
    chk("full_wr_count", wr_log.size(), DEPTH);
    chk("full_last_addr", wr_log[DEPTH-1], 'h1233);
    run_dump('h3FFF, 2, 1);
    chk("full_rb_wrap", got_log[1], dat('h07, 3, DEPTH - 'h1234));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
